// File: rtl/fixed_series_pkg.sv
// Shared widths, helpers and payload types for the fixed-point series datapath.
package fixed_series_pkg;

  localparam int DEF_OUT_W   = 8;
  localparam int DEF_IN_W    = 29;
  localparam int DEF_SHIFT_W = 6;

  // Two extra bits keep ALIGN_SHIFT - shift from overflowing for any exponent.
  function automatic int k_width(input int shift_w);
    return shift_w + 2;
  endfunction

  localparam int DEF_K_W = k_width(DEF_SHIFT_W);

  typedef struct packed {
    logic [DEF_IN_W-1:0]        data;
    logic signed [DEF_K_W-1:0]  k;
  } s1_payload_t;

endpackage

// File: rtl/fixed_round_shift_sat.sv
// Combinational power-of-two scaler: round-half-up right shift or left shift,
// followed by saturation to OUT_W bits.
module fixed_round_shift_sat #(
  parameter int IN_W  = 29,
  parameter int OUT_W = 8,
  parameter int K_W   = 8
) (
  input  logic [IN_W-1:0]       data_in,
  input  logic signed [K_W-1:0] k_in,
  output logic [OUT_W-1:0]      data_out,
  output logic                  sat_out
);

  localparam int LS_W = IN_W + OUT_W;

  // Returns {sat, value}; k > 0 shifts right with rounding, k < 0 shifts left.
  function automatic logic [OUT_W:0] round_shift_sat(input logic [IN_W-1:0] d,
                                                     input logic signed [K_W-1:0] k);
    logic [IN_W:0]   sum;
    logic [IN_W:0]   rs;
    logic [LS_W-1:0] ls;
    logic            sat;
    int              sh;
    sum = '0;
    rs  = '0;
    ls  = '0;
    sat = 1'b0;
    sh  = int'(k);
    if (sh > IN_W) begin
      return '0;
    end else if (sh > 0) begin
      // One extra bit holds the rounding carry.
      sum = {1'b0, d} + ((IN_W+1)'(1) << (sh - 1));
      rs  = sum >> sh;
      sat = (rs[IN_W:OUT_W] != '0);
      return sat ? {1'b1, {OUT_W{1'b1}}} : {1'b0, rs[OUT_W-1:0]};
    end else if (sh == 0) begin
      rs  = {1'b0, d};
      sat = (rs[IN_W:OUT_W] != '0);
      return sat ? {1'b1, {OUT_W{1'b1}}} : {1'b0, rs[OUT_W-1:0]};
    end else begin
      sh = -sh;
      // Any nonzero input shifted by OUT_W or more is out of range.
      if (sh >= OUT_W) begin
        sat = (d != '0);
        return sat ? {1'b1, {OUT_W{1'b1}}} : '0;
      end
      ls  = LS_W'(d) << sh;
      sat = (ls[LS_W-1:OUT_W] != '0);
      return sat ? {1'b1, {OUT_W{1'b1}}} : {1'b0, ls[OUT_W-1:0]};
    end
  endfunction

  logic [OUT_W:0] res;

  assign res      = round_shift_sat(data_in, k_in);
  assign data_out = res[OUT_W-1:0];
  assign sat_out  = res[OUT_W];

endmodule

// File: rtl/fixed_series_postscale.sv
// Streaming post-scaler: 2-stage valid/ready pipeline that applies an
// exponent-driven shift, round-half-up and saturation to the series result.
module fixed_series_postscale
  import fixed_series_pkg::*;
#(
  parameter int DATA_IN_0_PRECISION_0  = DEF_IN_W,
  parameter int DATA_OUT_0_PRECISION_0 = DEF_OUT_W,
  parameter int SHIFT_PRECISION_0      = DEF_SHIFT_W,
  parameter int ALIGN_SHIFT            = DATA_IN_0_PRECISION_0 - DATA_OUT_0_PRECISION_0
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [DATA_IN_0_PRECISION_0-1:0]  data_in_0,
  input  logic [SHIFT_PRECISION_0-1:0]      shift_in_0,
  input  logic                              data_in_0_valid,
  output logic                              data_in_0_ready,
  output logic [DATA_OUT_0_PRECISION_0-1:0] data_out_0,
  output logic                              sat_out_0,
  output logic                              data_out_0_valid,
  input  logic                              data_out_0_ready
);

  localparam int IN_W  = DATA_IN_0_PRECISION_0;
  localparam int OUT_W = DATA_OUT_0_PRECISION_0;
  localparam int K_W   = k_width(SHIFT_PRECISION_0);

  typedef struct packed {
    logic [IN_W-1:0]        data;
    logic signed [K_W-1:0]  k;
  } p1_t;

  logic signed [SHIFT_PRECISION_0-1:0] shift_s;
  logic signed [K_W-1:0]               k_in;
  logic                                s2_ready;

  p1_t              pay_p1;
  logic             vld_p1;
  logic [OUT_W-1:0] data_p2;
  logic             sat_p2;
  logic             vld_p2;
  logic [OUT_W-1:0] res_data;
  logic             res_sat;

  assign shift_s = $signed(shift_in_0);
  assign k_in    = $signed(K_W'(ALIGN_SHIFT)) - K_W'(shift_s);

  assign s2_ready        = !vld_p2 || data_out_0_ready;
  assign data_in_0_ready = !vld_p1 || s2_ready;

  // Stage 1: capture input value and effective shift
  always_ff @(posedge clk) begin
    if (data_in_0_valid && data_in_0_ready) begin
      pay_p1.data <= data_in_0;
      pay_p1.k    <= k_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1 <= 1'b0;
    end else if (data_in_0_ready) begin
      vld_p1 <= data_in_0_valid;
    end
  end

  // Stage 2: round, shift, saturate and register the output beat
  fixed_round_shift_sat #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W),
    .K_W   (K_W)
  ) u_rss (
    .data_in  (pay_p1.data),
    .k_in     (pay_p1.k),
    .data_out (res_data),
    .sat_out  (res_sat)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p2  <= 1'b0;
      data_p2 <= '0;
      sat_p2  <= 1'b0;
    end else if (s2_ready) begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        data_p2 <= res_data;
        sat_p2  <= res_sat;
      end
    end
  end

  assign data_out_0       = data_p2;
  assign sat_out_0        = sat_p2;
  assign data_out_0_valid = vld_p2;

endmodule

// File: tb/tb_fixed_series_postscale.sv
// Scoreboard bench for fixed_series_postscale: directed vectors push expected
// beats on accept, a monitor pops and compares whenever an output is presented.
module tb_fixed_series_postscale;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [28:0] data_in_0 = '0;
  logic [5:0]  shift_in_0 = '0;
  logic        data_in_0_valid = 1'b0;
  logic        data_in_0_ready;
  logic [7:0]  data_out_0;
  logic        sat_out_0;
  logic        data_out_0_valid;
  logic        data_out_0_ready = 1'b1;

  fixed_series_postscale dut (
    .clk              (clk),
    .rst              (rst),
    .data_in_0        (data_in_0),
    .shift_in_0       (shift_in_0),
    .data_in_0_valid  (data_in_0_valid),
    .data_in_0_ready  (data_in_0_ready),
    .data_out_0       (data_out_0),
    .sat_out_0        (sat_out_0),
    .data_out_0_valid (data_out_0_valid),
    .data_out_0_ready (data_out_0_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    logic       s;
    int         acc;
    bit         lat;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   n_acc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Drive one beat; returns after the accepting edge (+1).
  task automatic send(input logic [28:0] d, input logic [5:0] sh,
                      input logic [7:0] ed, input logic es, input bit lat);
    bit acc;
    bit done;
    exp_t e;
    data_in_0       = d;
    shift_in_0      = sh;
    data_in_0_valid = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      acc = data_in_0_ready;
      @(posedge clk);
      if (acc) done = 1'b1;
    end
    #1;
    if (!done) begin
      check("accept_timeout", 0, 1);
    end else begin
      e.d = ed; e.s = es; e.acc = cyc; e.lat = lat;
      q.push_back(e);
      n_acc++;
    end
    data_in_0_valid = 1'b0;
  endtask

  // Monitor: pop on transfer, check held value against the head while stalled.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && data_out_0_valid) begin
      if (q.size() == 0) begin
        check("unexpected_beat", 1, 0);
      end else if (data_out_0_ready) begin
        e = q.pop_front();
        check("data", data_out_0, e.d);
        check("sat", sat_out_0, e.s);
        // Valid appears after the edge following the accepting edge.
        if (e.lat) check("latency", cyc, e.acc + 1);
      end else begin
        check("stall_data", data_out_0, q[0].d);
        check("stall_sat", sat_out_0, q[0].s);
      end
    end
  end

  initial begin
    #2;
    check("rst_valid", data_out_0_valid, 0);
    check("rst_data", data_out_0, 0);
    check("rst_sat", sat_out_0, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", data_in_0_ready, 1);
    @(posedge clk); #1;

    // Directed vectors, exponent in 6-bit two's complement.
    send(29'd10485760, 6'd0,  8'd5,   1'b0, 1'b1);
    repeat (3) @(posedge clk); #1;
    send(29'd11534336, 6'd0,  8'd6,   1'b0, 1'b0);
    send(29'd11534335, 6'd0,  8'd5,   1'b0, 1'b0);
    send(29'd10485760, 6'd3,  8'd40,  1'b0, 1'b0);
    send(29'd10485760, 6'h21, 8'd0,   1'b0, 1'b0);
    send(29'h1FFFFFFF, 6'd0,  8'd255, 1'b1, 1'b0);
    send(29'd10485760, 6'd6,  8'd255, 1'b1, 1'b0);
    send(29'd3,        6'h3F, 8'd0,   1'b0, 1'b0);
    repeat (4) @(posedge clk); #1;

    // Backpressure: 5 beats while the output is stalled for 6 cycles.
    n_acc = 0;
    data_out_0_ready = 1'b0;
    fork
      begin
        for (int i = 1; i <= 5; i++)
          send(29'(i) << 21, 6'd0, 8'(i), 1'b0, 1'b0);
      end
      begin
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("bp_in_ready", data_in_0_ready, 0);
        check("bp_accepted", n_acc, 2);
        repeat (2) @(posedge clk);
        #1 data_out_0_ready = 1'b1;
      end
    join
    repeat (4) @(posedge clk); #1;
    check("bp_drained", q.size(), 0);

    // Reset with two beats in flight.
    send(29'd10485760, 6'd0, 8'd5, 1'b0, 1'b0);
    send(29'd11534336, 6'd0, 8'd6, 1'b0, 1'b0);
    rst = 1'b1;
    q.delete();
    #1;
    check("midrst_valid", data_out_0_valid, 0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (4) @(posedge clk); #1;
    send(29'd10485760, 6'd3, 8'd40, 1'b0, 1'b1);

    for (int i = 0; i < 100 && q.size() != 0; i++) @(posedge clk);
    @(negedge clk);
    check("final_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
